tp84_scan_flip_ctrl: RTL and testbench
======================================

# tp84_scan_flip_ctrl

Video scan controller that sequences the board's XOR-based screen-flip datapath. Generates the horizontal/vertical scan counters, blanking, sync and the vblank interrupt. Applies the CPU flip bit to the counters through XOR, committing flip changes only at vblank start so a frame is never torn. Sits between the CPU control latch and the tile/sprite address generators.

## Interface
Parameters:
- H_TOTAL, 384: dots per line; h_cnt counts 0..H_TOTAL-1.
- V_TOTAL, 264: lines per frame; v_cnt counts 0..V_TOTAL-1.
- HBL_START, 256: first blanked dot; hblank covers HBL_START..H_TOTAL-1.
- VBL_START, 240 / VBL_END, 16: vblank is v_cnt >= VBL_START or v_cnt < VBL_END.
- HS_START, 304 / HS_LEN, 32: hsync low for h_cnt in HS_START..HS_START+HS_LEN-1.
- VS_START, 248 / VS_LEN, 8: vsync low for v_cnt in VS_START..VS_START+VS_LEN-1.

Ports:
- clk_49m  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cen_6m  in  1  dot clock enable; all state advances only when high.
- flip_in  in  1  CPU flip-screen latch bit (level).
- irq_en  in  1  CPU interrupt-enable latch bit (level).
- irq_ack  in  1  one-clk_49m interrupt acknowledge pulse.
- h_cnt  out  9  raw horizontal count.
- v_cnt  out  9  raw vertical count.
- h_flip  out  8  h_cnt[7:0] XOR {8{flip_active}}.
- v_flip  out  8  v_cnt[7:0] XOR {8{flip_active}}.
- flip_active  out  1  committed flip state.
- hblank, vblank  out  1  blanking, active-high.
- hsync_n, vsync_n  out  1  sync, active-low.
- irq_n  out  1  vblank interrupt to CPU, active-low.
- frame_start  out  1  one-clk_49m pulse on the tick where v_cnt becomes VBL_START.

## Operation
- Reset (any cycle, irrespective of cen_6m): h_cnt=0, v_cnt=0, flip_active=0, irq_n=1, frame_start=0; hblank=0, vblank=1, hsync_n=1, vsync_n=1; h_flip=v_flip=0.
- On each cen_6m tick: h_cnt increments; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0.
- Frame = H_TOTAL*V_TOTAL = 101376 ticks at defaults.
- Flip commit: on the tick where h wraps and v_cnt goes VBL_START-1 -> VBL_START, flip_active <= flip_in. flip_in changes at any other time have no effect until then.
- IRQ latch: on that same tick, irq_n <= 0 if irq_en=1. While irq_en=0, irq_n is forced 1 (clears any pending). irq_ack=1 sets irq_n=1 on any clk_49m cycle.
- Priority: reset > irq_en=0 clear > set at vblank start > irq_ack. Set and ack in the same cycle leave irq_n=0.
- h_flip/v_flip XOR only bits [7:0]; bit 8 of the counters is never flipped.

## Timing
- All outputs are registered and are consistent with the counter values of the same cycle; no combinational path from inputs to outputs.
- Counter, blank, sync, flip and h_flip/v_flip update one clk_49m after the cen_6m-qualified edge.
- irq_n responds to irq_en/irq_ack one clk_49m after sampling, independent of cen_6m.
- frame_start is high for exactly the one clk_49m cycle following the commit tick.
- Flip latency: flip_in -> flip_active is 0..(frame-1) ticks, always landing at VBL_START.

## Configuration
- TP84_FLIP_DEFER_EN defined: flip commit deferred to vblank start as above.
- Not defined: flip_active <= flip_in on every cen_6m tick (one-tick latency, immediate). IRQ, counters and frame_start are unchanged.

## Structure
- Package tp84_video_pkg: default timing constants (H_TOTAL..VS_LEN) and typedef cnt9_t (9-bit counter).
- Sub-module tp84_vblank_irq: IRQ latch with set/ack/enable priority.

## Test plan
- Reset with cen_6m=1 for 10 cycles -> h_cnt=v_cnt=0, irq_n=1, vblank=1, hblank=0, flip_active=0.
- Run 384 ticks -> h_cnt wraps 383->0 with v_cnt 0->1; hblank high at h=256..383; hsync_n low at h=304..335.
- flip_in=1 at v=100 (DEFER_EN) -> flip_active stays 0 until v=240 tick; then at h=5, h_flip=8'hFA.
- irq_en=1 -> irq_n low at v=240, frame_start one pulse; irq_ack pulse -> irq_n=1 next cycle; irq_ack coincident with set -> irq_n=0.
- irq_en 1->0 while irq_n=0 -> irq_n=1 next cycle; with irq_en=0 through vblank start, irq_n stays 1.
- Reset asserted at v=250, h=100 -> all outputs return to reset values next cycle; count restarts from 0,0.

Source files
------------

// File: rtl/tp84_video_pkg.sv
// Default scan timing for the TP84 video board and the shared 9-bit counter type.
// The TP84_FLIP_DEFER_EN build option is consumed by tp84_scan_flip_ctrl.
package tp84_video_pkg;

  localparam int H_TOTAL   = 384;
  localparam int V_TOTAL   = 264;
  localparam int HBL_START = 256;
  localparam int VBL_START = 240;
  localparam int VBL_END   = 16;
  localparam int HS_START  = 304;
  localparam int HS_LEN    = 32;
  localparam int VS_START  = 248;
  localparam int VS_LEN    = 8;

  typedef logic [8:0] cnt9_t;

endpackage

// File: rtl/tp84_vblank_irq.sv
// Vblank interrupt latch: enable-low clears, vblank-start sets, CPU ack clears.
module tp84_vblank_irq (
  input  logic clk_49m,
  input  logic reset,
  input  logic i_irq_en,
  input  logic i_set,
  input  logic i_ack,
  output logic o_irq_n
);

  // Set outranks ack so an ack landing on the vblank-start edge cannot lose the new request.
  always_ff @(posedge clk_49m) begin
    if (reset)          o_irq_n <= 1'b1;
    else if (!i_irq_en) o_irq_n <= 1'b1;
    else if (i_set)     o_irq_n <= 1'b0;
    else if (i_ack)     o_irq_n <= 1'b1;
  end

endmodule

// File: rtl/tp84_scan_flip_ctrl.sv
// Scan counters, blanking/sync, vblank IRQ and XOR screen flip for the TP84 video board.
// Define TP84_FLIP_DEFER_EN to hold flip changes until vblank start; otherwise flip follows each dot tick.
module tp84_scan_flip_ctrl
  import tp84_video_pkg::cnt9_t;
#(
  parameter int H_TOTAL   = tp84_video_pkg::H_TOTAL,
  parameter int V_TOTAL   = tp84_video_pkg::V_TOTAL,
  parameter int HBL_START = tp84_video_pkg::HBL_START,
  parameter int VBL_START = tp84_video_pkg::VBL_START,
  parameter int VBL_END   = tp84_video_pkg::VBL_END,
  parameter int HS_START  = tp84_video_pkg::HS_START,
  parameter int HS_LEN    = tp84_video_pkg::HS_LEN,
  parameter int VS_START  = tp84_video_pkg::VS_START,
  parameter int VS_LEN    = tp84_video_pkg::VS_LEN
) (
  input  logic       clk_49m,
  input  logic       reset,
  input  logic       cen_6m,
  input  logic       flip_in,
  input  logic       irq_en,
  input  logic       irq_ack,
  output cnt9_t      h_cnt,
  output cnt9_t      v_cnt,
  output logic [7:0] h_flip,
  output logic [7:0] v_flip,
  output logic       flip_active,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       irq_n,
  output logic       frame_start
);

  localparam cnt9_t H_LAST    = cnt9_t'(H_TOTAL - 1);
  localparam cnt9_t V_LAST    = cnt9_t'(V_TOTAL - 1);
  localparam cnt9_t V_PRE_VBL = cnt9_t'(VBL_START - 1);
  localparam cnt9_t HBL_FIRST = cnt9_t'(HBL_START);
  localparam cnt9_t VBL_FIRST = cnt9_t'(VBL_START);
  localparam cnt9_t VBL_STOP  = cnt9_t'(VBL_END);
  localparam cnt9_t HS_FIRST  = cnt9_t'(HS_START);
  localparam cnt9_t HS_STOP   = cnt9_t'(HS_START + HS_LEN);
  localparam cnt9_t VS_FIRST  = cnt9_t'(VS_START);
  localparam cnt9_t VS_STOP   = cnt9_t'(VS_START + VS_LEN);

  cnt9_t w_h_nxt;
  cnt9_t w_v_nxt;
  logic  w_h_wrap;
  logic  w_commit;
  logic  w_flip_nxt;

  // Outputs are decoded from the next counter values so every registered output
  // matches the counters it is presented with.
  always_comb begin
    // NOTE: every combinational output is given a default first so no latch is inferred.
    w_h_nxt    = h_cnt;
    w_v_nxt    = v_cnt;
    w_h_wrap   = (h_cnt == H_LAST);
    w_commit   = cen_6m && w_h_wrap && (v_cnt == V_PRE_VBL);
    w_flip_nxt = flip_active;

    if (cen_6m) begin
      w_h_nxt = w_h_wrap ? '0 : h_cnt + 9'd1;
      if (w_h_wrap) w_v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 9'd1;
    end

`ifdef TP84_FLIP_DEFER_EN
    if (w_commit) w_flip_nxt = flip_in;
`else
    if (cen_6m) w_flip_nxt = flip_in;
`endif
  end

  always_ff @(posedge clk_49m) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_flip      <= '0;
      v_flip      <= '0;
      flip_active <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b1;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= w_h_nxt;
      v_cnt       <= w_v_nxt;
      h_flip      <= w_h_nxt[7:0] ^ {8{w_flip_nxt}};
      v_flip      <= w_v_nxt[7:0] ^ {8{w_flip_nxt}};
      flip_active <= w_flip_nxt;
      hblank      <= (w_h_nxt >= HBL_FIRST);
      vblank      <= (w_v_nxt >= VBL_FIRST) || (w_v_nxt < VBL_STOP);
      hsync_n     <= !((w_h_nxt >= HS_FIRST) && (w_h_nxt < HS_STOP));
      vsync_n     <= !((w_v_nxt >= VS_FIRST) && (w_v_nxt < VS_STOP));
      frame_start <= w_commit;
    end
  end

  tp84_vblank_irq u_irq (
    .clk_49m  (clk_49m),
    .reset    (reset),
    .i_irq_en (irq_en),
    .i_set    (w_commit),
    .i_ack    (irq_ack),
    .o_irq_n  (irq_n)
  );

endmodule

// File: tb/tb_tp84_scan_flip_ctrl.sv
// Randomized scoreboard bench for tp84_scan_flip_ctrl using a shortened frame.
// The reference model tracks a tick count within the frame and decodes outputs from it.
module tb_tp84_scan_flip_ctrl;

  localparam int H_T   = 320;
  localparam int V_T   = 24;
  localparam int HB_S  = 256;
  localparam int VB_S  = 20;
  localparam int VB_E  = 2;
  localparam int HS_S  = 272;
  localparam int HS_L  = 16;
  localparam int VS_S  = 21;
  localparam int VS_L  = 2;
  localparam int FRAME = H_T * V_T;
  localparam int N_CYC = 40000;

`ifdef TP84_FLIP_DEFER_EN
  localparam bit DEFER = 1'b1;
`else
  localparam bit DEFER = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic [7:0] hf;
    logic [7:0] vf;
    logic       fa;
    logic       hb;
    logic       vb;
    logic       hs_n;
    logic       vs_n;
    logic       irq_n;
    logic       fs;
  } obs_t;

  logic       clk_49m = 1'b0;
  logic       reset, cen_6m, flip_in, irq_en, irq_ack;
  logic [8:0] h_cnt, v_cnt;
  logic [7:0] h_flip, v_flip;
  logic       flip_active, hblank, vblank, hsync_n, vsync_n, irq_n, frame_start;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  obs_t sb_q[$];

  tp84_scan_flip_ctrl #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .HBL_START(HB_S), .VBL_START(VB_S), .VBL_END(VB_E),
    .HS_START(HS_S), .HS_LEN(HS_L), .VS_START(VS_S), .VS_LEN(VS_L)
  ) dut (
    .clk_49m     (clk_49m),
    .reset       (reset),
    .cen_6m      (cen_6m),
    .flip_in     (flip_in),
    .irq_en      (irq_en),
    .irq_ack     (irq_ack),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .h_flip      (h_flip),
    .v_flip      (v_flip),
    .flip_active (flip_active),
    .hblank      (hblank),
    .vblank      (vblank),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .irq_n       (irq_n),
    .frame_start (frame_start)
  );

  always #5 clk_49m = ~clk_49m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Position t within the frame fully determines counters, blanking and sync.
  function automatic obs_t model_obs(input int t, input bit fl, input bit irq, input bit fs);
    obs_t o;
    int   h = t % H_T;
    int   v = t / H_T;
    o.h     = 9'(h);
    o.v     = 9'(v);
    o.hf    = o.h[7:0] ^ {8{fl}};
    o.vf    = o.v[7:0] ^ {8{fl}};
    o.fa    = fl;
    o.hb    = (h >= HB_S);
    o.vb    = (v >= VB_S) || (v < VB_E);
    o.hs_n  = !(h >= HS_S && h < HS_S + HS_L);
    o.vs_n  = !(v >= VS_S && v < VS_S + VS_L);
    o.irq_n = irq;
    o.fs    = fs;
    return o;
  endfunction

  // Monitor: the DUT presents a full output set after every clock edge.
  initial begin
    obs_t exp_o, act_o;
    forever begin
      @(posedge clk_49m);
      #1;
      if (sb_q.size() > 0) begin
        exp_o = sb_q.pop_front();
        n_popped++;
        act_o = '{h: h_cnt, v: v_cnt, hf: h_flip, vf: v_flip, fa: flip_active,
                  hb: hblank, vb: vblank, hs_n: hsync_n, vs_n: vsync_n,
                  irq_n: irq_n, fs: frame_start};
        check("outputs", 64'(act_o), 64'(exp_o));
      end
    end
  end

  // Stimulus and reference model.
  initial begin
    int m_t    = 0;
    bit m_flip = 1'b0;
    bit m_irq  = 1'b1;
    bit m_fs   = 1'b0;
    bit mid_done = 1'b0;
    bit commit;
    reset   = 1'b1;
    cen_6m  = 1'b1;
    flip_in = 1'b0;
    irq_en  = 1'b0;
    irq_ack = 1'b0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk_49m);
      reset  = (cyc < 10);
      if (!mid_done && cyc > 12000 && m_t == (VB_S + 1) * H_T + 100) begin
        reset    = 1'b1;
        mid_done = 1'b1;
      end
      cen_6m = (cyc < 10) || ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1499) == 0) flip_in = ~flip_in;
      irq_en = (cyc >= 10) && (cyc < 22000 || cyc >= 34000) && ($urandom_range(0, 1999) != 0);

      commit  = !reset && cen_6m && (((m_t + 1) % FRAME) == VB_S * H_T);
      irq_ack = ($urandom_range(0, 49) == 0) || (commit && $urandom_range(0, 1) == 1);

      if (reset) begin
        m_t    = 0;
        m_flip = 1'b0;
        m_irq  = 1'b1;
        m_fs   = 1'b0;
      end else begin
        if (cen_6m) m_t = (m_t + 1) % FRAME;
        if (DEFER) begin
          if (commit) m_flip = flip_in;
        end else if (cen_6m) begin
          m_flip = flip_in;
        end
        if (!irq_en)      m_irq = 1'b1;
        else if (commit)  m_irq = 1'b0;
        else if (irq_ack) m_irq = 1'b1;
        m_fs = commit;
      end
      sb_q.push_back(model_obs(m_t, m_flip, m_irq, m_fs));
      n_pushed++;
    end

    repeat (3) @(negedge clk_49m);
    check("drain", 64'(n_popped), 64'(n_pushed));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
